axi_sram_slave: RTL and testbench

- AXI3 slave responder, the far end of the CPU's AXI master port.
- Owns a byte-writable single-port word memory and answers AR/R, AW/W/B transactions with INCR/FIXED bursts of up to 16 beats.
- Serves one transaction at a time. Used as the bench/SoC memory behind the CPU top level.

---
 rtl/axi_pkg.sv | 29 ++
 rtl/sram_1rw_be.sv | 32 +++
 rtl/axi_sram_slave.sv | 174 +++++++++++++++++
 tb/tb_axi_sram_slave.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 encodings, slave FSM states and the burst address step
// used by the SRAM-backed AXI responder.
package axi_pkg;

  localparam int ID_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_DATA,
    S_WR_RESP
  } state_e;

  // Plain 32-bit step: no 4KB boundary handling, FIXED (and reserved) hold.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    return (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;
  endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port word SRAM with per-byte write enables and a registered read.
module sram_1rw_be #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_q;

  // NOTE: the array and read register have no reset, which keeps them mappable onto SRAM macros.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_q <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one INCR/FIXED burst at a time from a byte-writable SRAM,
// alternating read/write grants under contention.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          MEM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  state_e          r_state, w_next_state;
  logic            r_rd_prio;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_addr;
  logic [3:0]      r_len, r_cnt;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic            r_err;

  logic        w_idle, w_rd_sel, w_ar_hs, w_aw_hs, w_r_hs, w_w_hs, w_b_hs;
  logic        w_in_range, w_rd_err, w_last, w_mem_en;
  logic [31:0] w_mem_q;
  logic        w_unused;

  assign w_unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                      arlen[7:4], awlen[7:4]};

  assign w_idle     = (r_state == S_IDLE);
  assign w_rd_sel   = arvalid & (~awvalid | r_rd_prio);
  assign w_ar_hs    = w_idle & w_rd_sel;
  assign w_aw_hs    = w_idle & awvalid & ~w_rd_sel;
  assign w_r_hs     = (r_state == S_RD_DATA) & rready;
  assign w_w_hs     = (r_state == S_WR_DATA) & wvalid;
  assign w_b_hs     = (r_state == S_WR_RESP) & bready;
  assign w_in_range = (r_addr[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
  assign w_last     = (r_cnt == r_len);
  // Read errors are judged per beat, so a burst can run off the end of the window.
  assign w_rd_err   = ~w_in_range | (r_burst == BURST_WRAP) | (r_size > 3'd2);
  assign w_mem_en   = ((r_state == S_RD_ADDR) & ~w_rd_err) | (w_w_hs & w_in_range & ~r_err);

  sram_1rw_be #(.AW(MEM_AW)) u_mem (
    .clk     (aclk),
    .i_en    (w_mem_en),
    .i_we    (w_w_hs),
    .i_be    (wstrb),
    .i_addr  (r_addr[MEM_AW+1:2]),
    .i_wdata (wdata),
    .o_rdata (w_mem_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_ar_hs) w_next_state = S_RD_ADDR;
                 else if (w_aw_hs) w_next_state = S_WR_DATA;
      S_RD_ADDR: w_next_state = S_RD_DATA;
      S_RD_DATA: if (rready) w_next_state = w_last ? S_IDLE : S_RD_ADDR;
      S_WR_DATA: if (wvalid && w_last) w_next_state = S_WR_RESP;
      S_WR_RESP: if (bready) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    arready = w_ar_hs;
    awready = w_aw_hs;
    wready  = (r_state == S_WR_DATA);
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rid     = '0;
    rdata   = '0;
    rresp   = RESP_OKAY;
    bvalid  = 1'b0;
    bid     = '0;
    bresp   = RESP_OKAY;
    if (r_state == S_RD_DATA) begin
      rvalid = 1'b1;
      rlast  = w_last;
      rid    = r_id;
      rdata  = w_rd_err ? 32'h0 : w_mem_q;
      rresp  = w_rd_err ? RESP_SLVERR : RESP_OKAY;
    end
    if (r_state == S_WR_RESP) begin
      bvalid = 1'b1;
      bid    = r_id;
      bresp  = r_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rd_prio <= 1'b1;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_err     <= 1'b0;
    end else if (w_ar_hs) begin
      r_rd_prio <= 1'b0;
      r_id      <= arid;
      r_addr    <= araddr;
      r_len     <= arlen[3:0];
      r_size    <= arsize;
      r_burst   <= arburst;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else if (w_aw_hs) begin
      r_rd_prio <= 1'b1;
      r_id      <= awid;
      r_addr    <= awaddr;
      r_len     <= awlen[3:0];
      r_size    <= awsize;
      r_burst   <= awburst;
      r_cnt     <= '0;
      r_err     <= (awburst == BURST_WRAP) | (awsize > 3'd2);
    end else if (w_r_hs && !w_last) begin
      r_cnt  <= r_cnt + 4'd1;
      r_addr <= next_addr(r_addr, r_size, r_burst);
    end else if (w_w_hs) begin
      if (!w_last) r_cnt <= r_cnt + 4'd1;
      r_addr <= next_addr(r_addr, r_size, r_burst);
      // A misplaced wlast poisons the response but the beat count still rules.
      if (!w_in_range || (wlast != w_last)) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a word-map model predicts every R and B
// beat, one compare process checks them each cycle, plus literal spot checks.
module tb_axi_sram_slave;
  import axi_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, awvalid, awready, wvalid, wready, wlast;
  logic        rvalid, rready, rlast, bvalid, bready;

  axi_sram_slave dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } bbeat_t;

  logic [31:0] mem_m [int unsigned];
  rbeat_t      rq[$];
  bbeat_t      bq[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] cap_data [16];
  logic [1:0]  cap_resp [16];
  logic [3:0]  cap_bid;
  logic [1:0]  cap_bresp;
  int          t_hs, first_rv;

  function automatic bit in_rng(input logic [31:0] a);
    return a[31:16] == 16'h1c00;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input int i);
    return (burst == BURST_INCR) ? a + 32'(i) * (32'd1 << size) : a;
  endfunction

  task automatic model_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a = beat_addr(addr, size, burst, i);
      bit bad = !in_rng(a) || burst == BURST_WRAP || size > 3'd2;
      rq.push_back('{id: id, data: bad ? 32'h0 : mem_m[a[15:2]],
                     resp: bad ? RESP_SLVERR : RESP_OKAY, last: (i == int'(len))});
    end
  endtask

  task automatic model_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int early);
    bit err = (burst == BURST_WRAP) || (size > 3'd2);
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a = beat_addr(addr, size, burst, i);
      bit wl = (early >= 0) ? (i == early) : (i == int'(len));
      if (in_rng(a) && !err) begin
        logic [31:0] w = mem_m.exists(a[15:2]) ? mem_m[a[15:2]] : 32'h0;
        for (int b = 0; b < 4; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
        mem_m[a[15:2]] = w;
      end else err = 1'b1;
      if (wl != (i == int'(len))) err = 1'b1;
    end
    bq.push_back('{id: id, resp: err ? RESP_SLVERR : RESP_OKAY});
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge aclk) begin
    if (!areset) begin
      if (rvalid || bvalid || wready) begin
        check("busy_arready", arready, 0);
        check("busy_awready", awready, 0);
      end
      if (rvalid) begin
        if (rq.size() == 0) check("r_unexpected", rvalid, 0);
        else begin
          check("r_data", rdata, rq[0].data);
          check("r_id",   rid,   rq[0].id);
          check("r_resp", rresp, rq[0].resp);
          check("r_last", rlast, rq[0].last);
          if (rready) void'(rq.pop_front());
        end
      end
      if (bvalid) begin
        if (bq.size() == 0) check("b_unexpected", bvalid, 0);
        else begin
          check("b_id",   bid,   bq[0].id);
          check("b_resp", bresp, bq[0].resp);
          if (bready) void'(bq.pop_front());
        end
      end
    end
  end

  // ---------------- drivers ----------------
  function automatic logic sig(input int which);
    case (which)
      0: return arready;
      1: return awready;
      2: return wready;
      3: return rvalid;
      default: return bvalid;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    bit hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge aclk);
      hit = sig(which);
    end
    if (!hit) check({name, "_timeout"}, 32'(hit), 1);
  endtask

  task automatic ar_set(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = addr; arlen = {4'h0, len}; arsize = size; arburst = burst; arvalid = 1'b1;
  endtask

  task automatic aw_set(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    awid = id; awaddr = addr; awlen = {4'h0, len}; awsize = size; awburst = burst; awvalid = 1'b1;
  endtask

  task automatic r_collect(input int nbeats, input bit stall);
    int got = 0;
    first_rv = -1;
    for (int c = 0; c < 200 && got < nbeats; c++) begin
      rready = stall ? (c % 2 == 0) : 1'b1;
      @(negedge aclk);
      if (rvalid && first_rv < 0) first_rv = cyc;
      if (rvalid && rready) begin
        cap_data[got] = rdata;
        cap_resp[got] = rresp;
        got++;
      end
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    if (got < nbeats) check("r_beat_count", 32'(got), 32'(nbeats));
  endtask

  task automatic w_send(input logic [3:0] len, input int early);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wlast  = (early >= 0) ? (i == early) : (i == int'(len));
      wait_for(2, "w_ready");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take();
    bready = 1'b1;
    wait_for(4, "b_valid");
    cap_bid = bid; cap_bresp = bresp;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit stall);
    model_read(id, addr, len, size, burst);
    ar_set(id, addr, len, size, burst);
    wait_for(0, "ar_grant");
    t_hs = cyc;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    r_collect(int'(len) + 1, stall);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int early);
    model_write(id, addr, len, size, burst, early);
    aw_set(id, addr, len, size, burst);
    wait_for(1, "aw_grant");
    @(posedge aclk); #1;
    awvalid = 1'b0;
    w_send(len, early);
    b_take();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    areset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arlock = '0; arcache = '0; arprot = '0; awlock = '0; awcache = '0; awprot = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    do_reset();

    @(negedge aclk);
    check("rst_arready", arready, 0); check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);   check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);     check("rst_bvalid", bvalid, 0);
    check("rst_rid", rid, 0);         check("rst_bid", bid, 0);
    check("rst_rdata", rdata, 0);     check("rst_rresp", rresp, 0);
    check("rst_bresp", bresp, 0);
    @(posedge aclk); #1;

    // Preload words 0..7, then the two test words.
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h1000_0000 + 32'(i); ws[i] = 4'hf; end
    do_write(4'd4, 32'h1c00_0000, 4'd7, 3'd2, BURST_INCR, -1);
    wd[0] = 32'hdead_beef; ws[0] = 4'hf;
    do_write(4'd1, 32'h1c00_0010, 4'd0, 3'd2, BURST_INCR, -1);
    wd[0] = 32'haaaa_aaaa;
    do_write(4'd2, 32'h1c00_0020, 4'd0, 3'd2, BURST_INCR, -1);

    // Single read and its two-cycle latency.
    do_read(4'd3, 32'h1c00_0010, 4'd0, 3'd2, BURST_INCR, 1'b0);
    check("rd_latency", 32'(first_rv - t_hs), 2);
    check("rd_deadbeef", cap_data[0], 32'hdead_beef);
    check("rd_deadbeef_resp", cap_resp[0], RESP_OKAY);

    // Partial-strobe write and readback.
    wd[0] = 32'h1234_5678; ws[0] = 4'b0011;
    do_write(4'd5, 32'h1c00_0020, 4'd0, 3'd2, BURST_INCR, -1);
    check("wr_bid", cap_bid, 4'd5);
    check("wr_bresp", cap_bresp, RESP_OKAY);
    do_read(4'd6, 32'h1c00_0020, 4'd0, 3'd2, BURST_INCR, 1'b0);
    check("rd_merged", cap_data[0], 32'haaaa_5678);

    // INCR burst with a stalling master.
    do_read(4'd3, 32'h1c00_0000, 4'd3, 3'd2, BURST_INCR, 1'b1);
    for (int i = 0; i < 4; i++) check($sformatf("incr_beat%0d", i), cap_data[i], 32'h1000_0000 + 32'(i));

    // FIXED burst re-reads one word.
    do_read(4'd1, 32'h1c00_0010, 4'd2, 3'd2, BURST_FIXED, 1'b0);
    check("fixed_beat2", cap_data[2], 32'hdead_beef);

    // Error paths.
    do_read(4'd2, 32'h0000_0000, 4'd0, 3'd2, BURST_INCR, 1'b0);
    check("oor_rresp", cap_resp[0], RESP_SLVERR);
    check("oor_rdata", cap_data[0], 32'h0);
    wd[0] = 32'hffff_ffff; ws[0] = 4'hf;
    do_write(4'd3, 32'h0000_0000, 4'd0, 3'd2, BURST_INCR, -1);
    check("oor_bresp", cap_bresp, RESP_SLVERR);
    do_read(4'd3, 32'h1c00_0000, 4'd0, 3'd2, BURST_INCR, 1'b0);
    check("oor_no_alias", cap_data[0], 32'h1000_0000);
    do_read(4'd4, 32'h1c00_0010, 4'd1, 3'd2, BURST_WRAP, 1'b0);
    check("wrap_resp0", cap_resp[0], RESP_SLVERR);
    check("wrap_resp1", cap_resp[1], RESP_SLVERR);
    for (int i = 0; i < 3; i++) begin wd[i] = 32'h5a00_0000 + 32'(i); ws[i] = 4'hf; end
    do_write(4'd7, 32'h1c00_0040, 4'd2, 3'd2, BURST_INCR, 1);
    check("early_wlast_bresp", cap_bresp, RESP_SLVERR);
    do_read(4'd7, 32'h1c00_0040, 4'd1, 3'd2, BURST_INCR, 1'b0);

    // Arbitration: read wins after reset, then strict alternation.
    do_reset();
    wd[0] = 32'hcafe_f00d; ws[0] = 4'hf;
    model_read(4'd7, 32'h1c00_0010, 4'd0, 3'd2, BURST_INCR);
    model_write(4'd8, 32'h1c00_0030, 4'd0, 3'd2, BURST_INCR, -1);
    ar_set(4'd7, 32'h1c00_0010, 4'd0, 3'd2, BURST_INCR);
    aw_set(4'd8, 32'h1c00_0030, 4'd0, 3'd2, BURST_INCR);
    @(negedge aclk);
    check("arb1_arready", arready, 1);
    check("arb1_awready", awready, 0);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    r_collect(1, 1'b0);
    model_read(4'd9, 32'h1c00_0030, 4'd0, 3'd2, BURST_INCR);
    ar_set(4'd9, 32'h1c00_0030, 4'd0, 3'd2, BURST_INCR);
    @(negedge aclk);
    check("arb2_awready", awready, 1);
    check("arb2_arready", arready, 0);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    w_send(4'd0, -1);
    b_take();
    wait_for(0, "arb3_grant");
    @(posedge aclk); #1;
    arvalid = 1'b0;
    r_collect(1, 1'b0);
    check("arb_readback", cap_data[0], 32'hcafe_f00d);

    // Reset in the middle of a long read.
    model_read(4'd2, 32'h1c00_0000, 4'd7, 3'd2, BURST_INCR);
    ar_set(4'd2, 32'h1c00_0000, 4'd7, 3'd2, BURST_INCR);
    wait_for(0, "rst_ar_grant");
    @(posedge aclk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    wait_for(3, "rst_beat1");
    @(posedge aclk); #1;
    rready = 1'b0;
    wait_for(3, "rst_beat2");
    areset = 1'b1;
    rready = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    rready = 1'b0;
    rq.delete();
    @(negedge aclk);
    check("midrst_rvalid", rvalid, 0);
    check("midrst_rlast", rlast, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_rid", rid, 0);
    @(posedge aclk); #1;
    do_read(4'd2, 32'h1c00_0000, 4'd7, 3'd2, BURST_INCR, 1'b0);
    check("midrst_beat1", cap_data[1], 32'h1000_0001);
    check("midrst_beat4", cap_data[4], 32'hdead_beef);
    check("midrst_beat7", cap_data[7], 32'h1000_0007);

    repeat (3) @(posedge aclk);
    check("rq_drained", 32'(rq.size()), 0);
    check("bq_drained", 32'(bq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
